// File: rtl/weight_enum_pkg.sv
// Shared types and helpers for the weight word enumerator.
// Word helpers are computed at MAX_W bits; callers truncate to DATA_WIDTH.
package weight_enum_pkg;

    localparam int unsigned MAX_W = 256;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width needed to hold a ones count in the range 0..dw
    function automatic int unsigned weight_w(input int unsigned dw);
        return $clog2(dw + 1);
    endfunction

    // Smallest word with k ones: (1<<k)-1
    function automatic logic [MAX_W-1:0] first_word(input int unsigned k);
        logic [MAX_W-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return (one << k) - one;
    endfunction

    // Largest dw-bit word with k ones: ((1<<k)-1) << (dw-k)
    function automatic logic [MAX_W-1:0] final_word(input int unsigned k, input int unsigned dw);
        return first_word(k) << (dw - k);
    endfunction

endpackage

// File: rtl/weight_word_enumerator_tzc.sv
// trailing_zero_count: combinational count of trailing zeros.
// The input is never zero when the result is used.
module trailing_zero_count
    import weight_enum_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] din,
    output logic [CNT_W-1:0]      cnt
);

    logic found;

    // Position of the lowest set bit
    always_comb begin
        cnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (!found && din[i]) begin
                cnt   = CNT_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/weight_word_enumerator.sv
// weight_word_enumerator: emits every DATA_WIDTH-bit word with exactly
// `weight` ones, ascending, one word per valid/ready handshake.
// Optional feature macro WEIGHT_ENUM_INDEX_EN adds the out_index port/counter.
module weight_word_enumerator
    import weight_enum_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned INDEX_WIDTH = 32,
    localparam int unsigned WEIGHT_W   = weight_w(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WEIGHT_W-1:0]    weight,
    output logic                   busy,
    output logic                   err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   last
`ifdef WEIGHT_ENUM_INDEX_EN
    ,output logic [INDEX_WIDTH-1:0] out_index
`endif
);

    localparam int unsigned TZ_W = $clog2(DATA_WIDTH);

    if (DATA_WIDTH < 2 || INDEX_WIDTH < 1) begin : g_cfg_check
        $error("weight_word_enumerator: DATA_WIDTH must be >= 2 and INDEX_WIDTH >= 1");
    end

    state_t                  state;
    logic [WEIGHT_W-1:0]     k;
    logic [DATA_WIDTH-1:0]   c;
    logic [DATA_WIDTH-1:0]   r;
    logic [DATA_WIDTH-1:0]   nxt;
    logic [DATA_WIDTH-1:0]   fin;
    logic [DATA_WIDTH-1:0]   init_word;
    logic [TZ_W-1:0]         tz;
    logic                    weight_bad;
    logic                    init_last;

    trailing_zero_count #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_tzc (
        .din(data_out),
        .cnt(tz)
    );

    assign busy      = (state == RUN);
    assign out_valid = (state == RUN);

    // Gosper step: next larger word with the same ones count
    always_comb begin
        c   = data_out & (-data_out);
        r   = data_out + c;
        nxt = r | (((data_out ^ r) >> 2) >> tz);
    end

    // Start-time decode and final-word reference for the latched weight
    always_comb begin
        fin        = DATA_WIDTH'(final_word(32'(k), DATA_WIDTH));
        init_word  = DATA_WIDTH'(first_word(32'(weight)));
        weight_bad = (weight > WEIGHT_W'(DATA_WIDTH));
        init_last  = (weight == '0) || (weight == WEIGHT_W'(DATA_WIDTH));
    end

    // Control FSM and output word registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            data_out <= '0;
            last     <= 1'b0;
            err      <= 1'b0;
`ifdef WEIGHT_ENUM_INDEX_EN
            out_index <= '0;
`endif
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (weight_bad) begin
                            err <= 1'b1;
                        end else begin
                            k        <= weight;
                            data_out <= init_word;
                            last     <= init_last;
                            state    <= RUN;
`ifdef WEIGHT_ENUM_INDEX_EN
                            out_index <= '0;
`endif
                        end
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (last) begin
                            last  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            data_out <= nxt;
                            last     <= (nxt == fin);
`ifdef WEIGHT_ENUM_INDEX_EN
                            out_index <= out_index + INDEX_WIDTH'(1);
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_word_enumerator.sv
// Scoreboard bench for weight_word_enumerator at DATA_WIDTH=8.
// Expected words are queued by the stimulus; a negedge monitor pops and compares.
module tb_weight_word_enumerator;

    localparam int DW = 8;
    localparam int IW = 8;
    localparam int WW = $clog2(DW + 1);

    localparam logic [7:0] W2 [28] = '{
        8'h03, 8'h05, 8'h06, 8'h09, 8'h0A, 8'h0C, 8'h11, 8'h12, 8'h14, 8'h18,
        8'h21, 8'h22, 8'h24, 8'h28, 8'h30, 8'h41, 8'h42, 8'h44, 8'h48, 8'h50,
        8'h60, 8'h81, 8'h82, 8'h84, 8'h88, 8'h90, 8'hA0, 8'hC0
    };
    localparam logic [7:0] W1 [8] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
    };
    localparam logic [7:0] W4_HEAD [5] = '{8'h0F, 8'h17, 8'h1B, 8'h1D, 8'h1E};

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [WW-1:0] weight = '0;
    logic          busy;
    logic          err;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] data_out;
    logic          last;
`ifdef WEIGHT_ENUM_INDEX_EN
    logic [IW-1:0] out_index;
`endif

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_count = 0;

    weight_word_enumerator #(
        .DATA_WIDTH(DW),
        .INDEX_WIDTH(IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .weight(weight),
        .busy(busy),
        .err(err),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out(data_out),
        .last(last)
`ifdef WEIGHT_ENUM_INDEX_EN
        ,.out_index(out_index)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic l, input int i);
        exp_t e;
        e.data = d;
        e.last = l;
        e.idx  = i;
        q.push_back(e);
    endtask

    // Reference: brute-force scan of all 8-bit values in ascending order
    task automatic push_model(input int k);
        logic [7:0] tmp[$];
        logic [7:0] v8;
        for (int v = 0; v < 256; v++) begin
            v8 = 8'(v);
            if ($countones(v8) == k) tmp.push_back(v8);
        end
        for (int i = 0; i < tmp.size(); i++) push_exp(tmp[i], i == tmp.size() - 1, i);
    endtask

    // Monitor: compare every accepted word against the scoreboard head
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            hs_count++;
            if (q.size() == 0) begin
                check("unexpected_word", {24'h0, data_out}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("data_out", {24'h0, data_out}, {24'h0, e.data});
                check("last", {31'h0, last}, {31'h0, e.last});
`ifdef WEIGHT_ENUM_INDEX_EN
                check("out_index", {24'h0, out_index}, 32'(e.idx));
`endif
            end
        end
    end

    task automatic start_seq(input int k);
        @(posedge clk); #1;
        start  = 1'b1;
        weight = WW'(k);
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    // Wait for the scoreboard to drain, then require IDLE right after the last handshake
    task automatic wait_done(input string name);
        int n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) begin
            check({name, "_timeout"}, 32'(q.size()), 32'h0);
            q.delete();
        end
        check({name, "_busy_after"}, {31'h0, busy}, 32'h0);
        check({name, "_valid_after"}, {31'h0, out_valid}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int hs0;
        int n;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_data", {24'h0, data_out}, 32'h0);
        check("rst_last", {31'h0, last}, 32'h0);
`ifdef WEIGHT_ENUM_INDEX_EN
        check("rst_index", {24'h0, out_index}, 32'h0);
`endif
        rst = 1'b0;

        // Weight 2 full sequence
        out_ready = 1'b1;
        for (int i = 0; i < 28; i++) push_exp(W2[i], i == 27, i);
        hs0 = hs_count;
        start_seq(2);
        wait_done("w2");
        check("w2_count", 32'(hs_count - hs0), 32'd28);

        // Degenerate weights 0 and 8
        push_exp(8'h00, 1'b1, 0);
        start_seq(0);
        wait_done("w0");
        push_exp(8'hFF, 1'b1, 0);
        start_seq(8);
        wait_done("w8");

        // Out-of-range weight
        @(posedge clk); #1;
        start  = 1'b1;
        weight = WW'(9);
        @(posedge clk); #1;
        start  = 1'b0;
        check("err_pulse", {31'h0, err}, 32'h1);
        check("err_busy", {31'h0, busy}, 32'h0);
        check("err_valid", {31'h0, out_valid}, 32'h0);
        @(posedge clk); #1;
        check("err_clear", {31'h0, err}, 32'h0);
        check("err_valid2", {31'h0, out_valid}, 32'h0);

        // Stall on the first word of weight 3
        out_ready = 1'b0;
        push_model(3);
        start_seq(3);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", {31'h0, out_valid}, 32'h1);
            check("stall_data", {24'h0, data_out}, 32'h07);
            check("stall_last", {31'h0, last}, 32'h0);
`ifdef WEIGHT_ENUM_INDEX_EN
            check("stall_index", {24'h0, out_index}, 32'h0);
`endif
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done("w3");

        // Abort weight 4 with reset after 5 handshakes
        for (int i = 0; i < 5; i++) push_exp(W4_HEAD[i], 1'b0, i);
        hs0 = hs_count;
        start_seq(4);
        n = 0;
        while ((hs_count - hs0) < 5 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_hs", 32'(hs_count - hs0), 32'd5);
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_valid", {31'h0, out_valid}, 32'h0);
        check("abort_data", {24'h0, data_out}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_last", {31'h0, last}, 32'h0);
        check("abort_leftover", 32'(q.size()), 32'h0);
        q.delete();

        // Fresh weight 1 sequence after abort
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_exp(W1[i], i == 7, i);
        start_seq(1);
        wait_done("w1");

        // Start pulse during RUN must be ignored
        for (int i = 0; i < 28; i++) push_exp(W2[i], i == 27, i);
        hs0 = hs_count;
        start_seq(2);
        repeat (3) begin
            @(posedge clk); #1;
        end
        start  = 1'b1;
        weight = WW'(5);
        @(posedge clk); #1;
        start  = 1'b0;
        wait_done("w2_ignore");
        check("w2_ignore_count", 32'(hs_count - hs0), 32'd28);
        repeat (3) @(posedge clk);
        #1;
        check("w2_ignore_idle", {31'h0, busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
